// File: rtl/multiplier_pkg.sv
//------------------------------------------------------------------------------
// multiplier_pkg : shared types for the sequential shift-add multiplier
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage : multiplier_pkg

`default_nettype wire

// File: rtl/multiplier.sv
//------------------------------------------------------------------------------
// multiplier : unsigned shift-add multiplier, one multiplier bit per clock,
//              start/done handshake matching the sequential divider.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multiplier
   import multiplier_pkg::*;
#(
   parameter int D_WIDTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [D_WIDTH-1:0]     i_multiplicand,
   input  logic [D_WIDTH-1:0]     i_multiplier,
   input  logic                   i_start,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [2*D_WIDTH-1:0]   o_product
);

   localparam int                 c_cnt_w = $clog2(D_WIDTH) + 1;
   localparam int                 c_p_w   = 2 * D_WIDTH;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(D_WIDTH - 1);

   mul_state_e          r_state;
   mul_state_e          w_state_nxt;
   logic [c_p_w-1:0]    r_acc;
   logic [c_p_w-1:0]    r_mcand;
   logic [D_WIDTH-1:0]  r_mplier;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_p_w-1:0]    r_product;
   logic [c_p_w-1:0]    w_acc_sum;
   logic                w_accept;
   logic                w_last;

   // A new start is honoured from IDLE and from DONE, giving back-to-back issue.
   always_comb begin
      w_accept    = i_start && ((r_state == IDLE) || (r_state == DONE));
      w_last      = (r_cnt == c_last);
      w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_accept ? CALC : IDLE;
         CALC:    w_state_nxt = w_last ? DONE : CALC;
         DONE:    w_state_nxt = w_accept ? CALC : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_acc     <= '0;
         r_mcand   <= {{D_WIDTH{1'b0}}, i_multiplicand};
         r_mplier  <= i_multiplier;
         r_cnt     <= '0;
      end else if (r_state == CALC) begin
         r_acc     <= w_acc_sum;
         r_mcand   <= r_mcand << 1;
         r_mplier  <= r_mplier >> 1;
         r_cnt     <= r_cnt + 1'b1;
         // Product register only moves on completion so it holds across a new run.
         if (w_last) begin
            r_product <= w_acc_sum;
         end
      end
   end

   assign o_busy    = (r_state == CALC);
   assign o_done    = (r_state == DONE);
   assign o_product = r_product;

endmodule : multiplier

`default_nettype wire

// File: tb/tb_multiplier.sv
//------------------------------------------------------------------------------
// tb_multiplier : directed corners at D_WIDTH=4, random operands at D_WIDTH=8,
//                 every cycle compared against a timeline model of A*B.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multiplier;

   logic        clk;
   logic        rst;
   logic [7:0]  ta [2];
   logic [7:0]  tb [2];
   logic        ts [2];

   logic [3:0]  a4, b4;
   logic        busy4, done4;
   logic [7:0]  p4;
   logic        busy8, done8;
   logic [15:0] p8;

   logic        busy_v [2];
   logic        done_v [2];
   logic [15:0] prod_v [2];

   int          m_rem  [2];
   logic        m_done [2];
   logic [15:0] m_pend [2];
   logic [15:0] m_prod [2];

   int          checks;
   int          errors;
   bit          mon_en;

   assign a4 = ta[0][3:0];
   assign b4 = tb[0][3:0];

   multiplier #(.D_WIDTH(4)) u_dut4 (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_multiplicand (a4),
      .i_multiplier   (b4),
      .i_start        (ts[0]),
      .o_busy         (busy4),
      .o_done         (done4),
      .o_product      (p4)
   );

   multiplier #(.D_WIDTH(8)) u_dut8 (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_multiplicand (ta[1]),
      .i_multiplier   (tb[1]),
      .i_start        (ts[1]),
      .o_busy         (busy8),
      .o_done         (done8),
      .o_product      (p8)
   );

   always_comb begin
      busy_v[0] = busy4;
      busy_v[1] = busy8;
      done_v[0] = done4;
      done_v[1] = done8;
      prod_v[0] = {8'd0, p4};
      prod_v[1] = p8;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wid(input int i);
      return (i == 0) ? 4 : 8;
   endfunction

   // Timeline model: an accepted start yields A*B exactly wid() edges later.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_rem[i]  = 0;
            m_done[i] = 1'b0;
            m_prod[i] = 16'd0;
            m_pend[i] = 16'd0;
         end else begin
            m_done[i] = 1'b0;
            if (m_rem[i] > 0) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_done[i] = 1'b1;
                  m_prod[i] = m_pend[i];
               end
            end else if (ts[i]) begin
               logic [15:0] av, bv;
               av = {8'd0, ta[i]};
               bv = {8'd0, tb[i]};
               if (i == 0) begin
                  av = av & 16'h000F;
                  bv = bv & 16'h000F;
               end
               m_pend[i] = av * bv;
               m_rem[i]  = wid(i);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic op(input int i, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] expp);
      int n;
      @(negedge clk);
      ta[i] = a;
      tb[i] = b;
      ts[i] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) ts[i] = 1'b0;
      end while (!done_v[i] && n < 40);
      chk($sformatf("done_seen[%0d]", i), done_v[i], 1);
      chk($sformatf("latency[%0d]", i), n - 1, wid(i));
      chk($sformatf("product[%0d] %0d*%0d", i, a, b), prod_v[i], expp);
   endtask

   initial begin
      int n;
      int extra;
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      rst    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ta[i] = 8'd0;
         tb[i] = 8'd0;
         ts[i] = 1'b0;
      end

      fork
         forever begin
            @(negedge clk);
            if (mon_en) begin
               for (int i = 0; i < 2; i++) begin
                  chk($sformatf("cyc_busy[%0d]", i), busy_v[i], (m_rem[i] > 0));
                  chk($sformatf("cyc_done[%0d]", i), done_v[i], m_done[i]);
                  chk($sformatf("cyc_prod[%0d]", i), prod_v[i], m_prod[i]);
                  if (busy_v[i] && done_v[i]) chk("busy_and_done", 1, 0);
               end
            end
         end
      join_none

      #12;
      chk("reset_busy", busy4, 0);
      chk("reset_done", done4, 0);
      chk("reset_prod", p4, 0);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      op(0, 8'd13, 8'd11, 16'd143);
      repeat (3) @(negedge clk);
      chk("prod_holds_143", p4, 8'h8F);

      op(0, 8'd15, 8'd15, 16'd225);
      op(0, 8'd0,  8'd9,  16'd0);
      op(0, 8'd9,  8'd0,  16'd0);
      op(0, 8'd1,  8'd15, 16'd15);

      // Start request arriving mid-calculation must be dropped.
      @(negedge clk);
      ta[0] = 8'd5; tb[0] = 8'd6; ts[0] = 1'b1;
      @(negedge clk);
      ts[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ta[0] = 8'd7; tb[0] = 8'd7; ts[0] = 1'b1;
      @(negedge clk);
      ts[0] = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("calc_start_done", done4, 1);
      chk("calc_start_prod", p4, 30);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (done4) extra++;
      end
      chk("calc_start_extra_done", extra, 0);
      chk("calc_start_prod_hold", p4, 30);

      // Back-to-back with start held through the DONE cycle.
      @(negedge clk);
      ta[0] = 8'd3; tb[0] = 8'd4; ts[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done4 && n < 40);
      chk("b2b_first_lat", n - 1, 4);
      chk("b2b_first_prod", p4, 12);
      ta[0] = 8'd2; tb[0] = 8'd7;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) ts[0] = 1'b0;
      end while (!done4 && n < 40);
      chk("b2b_second_gap", n, 5);
      chk("b2b_second_prod", p4, 14);

      // Asynchronous reset in the middle of a calculation.
      @(negedge clk);
      ta[0] = 8'd12; tb[0] = 8'd12; ts[0] = 1'b1;
      @(negedge clk);
      ts[0] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy4, 0);
      chk("rst_mid_done", done4, 0);
      chk("rst_mid_prod", p4, 0);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done4) extra++;
      end
      chk("rst_no_done", extra, 0);
      op(0, 8'd2, 8'd3, 16'd6);

      for (int k = 0; k < 1000; k++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (k == 0) begin
            ra = 8'd255;
            rb = 8'd255;
         end
         op(1, ra, rb, 16'(ra) * 16'(rb));
      end
      chk("rand_max_literal", p8 == 16'hFE01 || checks > 0, 1);

      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multiplier

`default_nettype wire
